// File: rtl/mix_arb_pkg.sv
// Shared definitions for the mixer bus arbiter: requester count, encoded
// grant width, hold-counter width, FSM state type and a one-hot helper.
package mix_arb_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned ID_W  = 3;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [ID_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mix_arb_pick.sv
// Combinational winner selection for the mixer bus arbiter.
// Ports:
//   req [7:0] : request vector, one bit per source
//   ptr [2:0] : last owner; the ring is rotated so source ptr+1 is examined first
//   id  [2:0] : encoded winner (valid only when any=1)
//   any       : at least one request is present
// Build option MIX_ARB_ROUND_ROBIN_EN: when defined, the first requester met
// walking upward from ptr+1 wins (last owner lowest). When undefined, the
// top ties ptr to 7 (rotation of zero) and the highest set index wins.
module mix_arb_pick
   import mix_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  id,
   output logic             any
);

   logic [ID_W-1:0]  w_shift;
   logic [ID_W-1:0]  w_idx;
   logic [ID_W-1:0]  w_pos;
   logic [N_REQ-1:0] w_rot;

   // w_rot[k] holds req[(ptr+1+k) mod 8]; 3-bit arithmetic gives the wrap.
   always_comb begin
      w_shift = ptr + 3'd1;
      w_idx   = '0;
      w_rot   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_idx    = ID_W'(k) + w_shift;
         w_rot[k] = req[w_idx];
      end
   end

   always_comb begin
      w_pos = '0;
`ifdef MIX_ARB_ROUND_ROBIN_EN
      // Scan downward so the lowest rotated position (nearest ptr+1) wins.
      for (int unsigned k = N_REQ; k > 0; k--) begin
         if (w_rot[k-1]) w_pos = ID_W'(k - 1);
      end
`else
      // Scan upward so the highest set position wins.
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (w_rot[k]) w_pos = ID_W'(k);
      end
`endif
   end

   assign id  = w_pos + w_shift;
   assign any = |req;

endmodule

// File: rtl/mix_bus_arbiter.sv
// Arbiter sharing the mixer accumulator/sample bus among 8 audio sources.
// A grant is held until the owner pulses rel, drops its request, or the
// HOLD_MAX cycle bound expires; one dead cycle separates successive owners.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req [7:0]      : requests, bit 7 highest fixed priority
//   rel            : release strobe from the current owner
//   gnt [7:0]      : one-hot grant, zero when no owner
//   gnt_id [2:0]   : encoded owner, zero when no owner
//   gnt_valid      : grant active
//   timeout        : one-cycle pulse when HOLD_MAX forced the release
// Build option MIX_ARB_ROUND_ROBIN_EN: rotating priority with a last-owner
// pointer; fixed priority when undefined.
module mix_bus_arbiter
   import mix_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 8,
   parameter int unsigned HOLD_MAX = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic       rel,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   generate
      if (N_REQ != mix_arb_pkg::N_REQ) begin : g_bad_nreq
         $error("mix_bus_arbiter: N_REQ must be 8");
      end
      if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
         $error("mix_bus_arbiter: HOLD_MAX must be in 2..255");
      end
   endgenerate

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       r_gnt;
   logic [7:0]       w_gnt_nxt;
   logic [ID_W-1:0]  r_id;
   logic [ID_W-1:0]  w_id_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;

   logic [ID_W-1:0]  w_ptr;
   logic [ID_W-1:0]  w_pick_id;
   logic             w_pick_any;
   logic             w_rel_end;
   logic             w_hold_end;

`ifdef MIX_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0]  r_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '1;
      end else if (r_state != OWN && w_pick_any) begin
         r_ptr <= w_pick_id;
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = '1;
`endif

   mix_arb_pick u_pick (
      .req (req),
      .ptr (w_ptr),
      .id  (w_pick_id),
      .any (w_pick_any)
   );

   // A release or request drop is a normal end and suppresses the timeout
   // pulse even when the counter bound is reached on the same edge.
   assign w_rel_end  = rel | ~req[r_id];
   assign w_hold_end = (r_cnt == HOLD_LAST);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_gnt_nxt     = r_gnt;
      w_id_nxt      = r_id;
      w_valid_nxt   = r_valid;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE, GAP: begin
            w_cnt_nxt = '0;
            if (w_pick_any) begin
               w_state_nxt = OWN;
               w_gnt_nxt   = idx_to_onehot(w_pick_id);
               w_id_nxt    = w_pick_id;
               w_valid_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_id_nxt    = '0;
               w_valid_nxt = 1'b0;
            end
         end
         OWN: begin
            if (w_rel_end || w_hold_end) begin
               w_state_nxt   = GAP;
               w_cnt_nxt     = '0;
               w_gnt_nxt     = '0;
               w_id_nxt      = '0;
               w_valid_nxt   = 1'b0;
               w_timeout_nxt = ~w_rel_end;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_gnt_nxt   = '0;
            w_id_nxt    = '0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_id      <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_gnt     <= w_gnt_nxt;
         r_id      <= w_id_nxt;
         r_valid   <= w_valid_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_id    = r_id;
   assign gnt_valid = r_valid;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_mix_bus_arbiter.sv
// Testbench for mix_bus_arbiter (HOLD_MAX=4). Stimulus queues the expected
// grant episodes (start cycle, owner, length, timeout at end); a negedge
// monitor pops and checks each episode as the DUT presents it.
module tb_mix_bus_arbiter;

   localparam int unsigned HOLD = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic       rel;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   always #5 clk = ~clk;

   mix_bus_arbiter #(.N_REQ(8), .HOLD_MAX(HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .rel       (rel),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   typedef struct {
      int unsigned start;
      int unsigned id;
      int unsigned len;
      bit          to;
   } exp_t;

   exp_t        q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input int unsigned start, input int unsigned id,
                               input int unsigned len, input bit to);
      exp_t e;
      e.start = start;
      e.id    = id;
      e.len   = len;
      e.to    = to;
      q.push_back(e);
   endtask

   // Monitor
   bit          prev_v   = 1'b0;
   bit          have_cur = 1'b0;
   exp_t        cur;
   int unsigned run_len  = 0;
   logic [7:0]  exp_oh;

   always @(negedge clk) begin
      if (cyc >= 1) begin
         if (gnt_valid === 1'b1 && !prev_v) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_grant: got id %0d expected no grant (cycle %0d)", gnt_id, cyc);
               have_cur = 1'b0;
            end else begin
               cur      = q.pop_front();
               have_cur = 1'b1;
               exp_oh   = 8'h01 << cur.id;
               check("grant_start_cycle", cyc, cur.start);
               check("gnt_id", 32'(gnt_id), cur.id);
               check("gnt_onehot", 32'(gnt), 32'(exp_oh));
            end
            run_len = 1;
            check("timeout_at_start", 32'(timeout), 0);
         end else if (gnt_valid === 1'b1) begin
            run_len++;
            if (have_cur) check("gnt_id_held", 32'(gnt_id), cur.id);
            check("timeout_in_grant", 32'(timeout), 0);
         end else if (prev_v) begin
            if (have_cur) begin
               check("grant_length", run_len, cur.len);
               check("timeout_at_end", 32'(timeout), 32'(cur.to));
            end
            check("gnt_clear", 32'(gnt), 0);
            check("gnt_id_clear", 32'(gnt_id), 0);
            have_cur = 1'b0;
         end else begin
            check("timeout_idle", 32'(timeout), 0);
         end
         prev_v = (gnt_valid === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   int unsigned c;

   initial begin
      reset = 1'b1;
      req   = '0;
      rel   = 1'b0;
      step();
      step();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_gnt_id", 32'(gnt_id), 0);
      check("rst_gnt_valid", 32'(gnt_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      reset = 1'b0;
      step();

      // Reset in the middle of a grant to source 3
      c   = cyc;
      req = 8'h08;
      expect_grant(c + 1, 3, 2, 1'b0);
      step();
      step();
      reset = 1'b1;
      req   = '0;
      step();
      check("midrst_gnt", 32'(gnt), 0);
      check("midrst_gnt_valid", 32'(gnt_valid), 0);
      check("midrst_timeout", 32'(timeout), 0);
      reset = 1'b0;
      step();

`ifdef MIX_ARB_ROUND_ROBIN_EN
      // All sources request; each owner releases immediately
      c   = cyc;
      req = 8'hFF;
      for (int unsigned k = 0; k < 9; k++) expect_grant(c + 1 + 2 * k, k % 8, 1, 1'b0);
      for (int unsigned k = 0; k < 9; k++) begin
         step();
         rel = 1'b1;
         if (k == 8) req = '0;
         step();
         rel = 1'b0;
      end
      step();
`else
      // Fixed priority; source 7 arriving mid-grant must not preempt,
      // then release with 7 and 0 waiting
      c   = cyc;
      req = 8'b0010_1001;
      expect_grant(c + 1, 5, 2, 1'b0);
      expect_grant(c + 4, 7, 1, 1'b0);
      step();
      req = 8'b1010_1001;
      step();
      rel = 1'b1;
      req = 8'b1000_0001;
      step();
      rel = 1'b0;
      step();
      req = '0;
      step();
      step();

      // Owner drops its request
      c   = cyc;
      req = 8'h04;
      expect_grant(c + 1, 2, 2, 1'b0);
      step();
      step();
      req = '0;
      step();
      step();

      // Release and request drop together
      c   = cyc;
      req = 8'h40;
      expect_grant(c + 1, 6, 2, 1'b0);
      step();
      step();
      rel = 1'b1;
      req = '0;
      step();
      rel = 1'b0;
      step();

      // Release while idle is ignored: grant still issued
      c   = cyc;
      rel = 1'b1;
      req = 8'h10;
      expect_grant(c + 1, 4, 2, 1'b0);
      step();
      rel = 1'b0;
      step();
      req = '0;
      step();
      step();

      // Timeout after HOLD cycles, then re-grant after the gap
      c   = cyc;
      req = 8'h02;
      expect_grant(c + 1, 1, HOLD, 1'b1);
      expect_grant(c + 6, 1, 1, 1'b0);
      repeat (6) step();
      rel = 1'b1;
      req = '0;
      step();
      rel = 1'b0;
      step();

      // Release on the bound edge wins over timeout
      c   = cyc;
      req = 8'h02;
      expect_grant(c + 1, 1, HOLD, 1'b0);
      repeat (4) step();
      rel = 1'b1;
      req = '0;
      step();
      rel = 1'b0;
      step();

      // Continuous requester wins again after its own release
      c   = cyc;
      req = 8'h20;
      expect_grant(c + 1, 5, 1, 1'b0);
      expect_grant(c + 3, 5, 1, 1'b0);
      step();
      rel = 1'b1;
      step();
      rel = 1'b0;
      step();
      req = '0;
      step();
      step();
`endif

      repeat (3) step();
      check("pending_expectations", q.size(), 0);
      check("final_gnt_valid", 32'(gnt_valid), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
